multiply: RTL and testbench

- Sequential 64x64 integer multiplier for the processing unit's ALU/execute path.
- Returns either the low or the high 64 bits of the 128-bit product. The operand signedness is selected by a 2-bit flag: MUL, MULH, MULHSU and MULHU semantics.
- Multi-cycle, shift-add, one operation in flight, with a start/busy/done handshake.

---
 rtl/multiply.sv | 100 ++++++++++
 tb/tb_multiply.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/multiply.sv
// Sequential shift-add 64x64 multiplier returning the low or high half of the
// 128-bit product (MUL / MULH / MULHSU / MULHU), one operation in flight.
module multiply #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [1:0]       flag,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t               state;
  logic [2*WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]     mplier;
  logic [2*WIDTH-1:0]   acc;
  logic [CW-1:0]        cnt;
  logic                 neg;
  logic                 hi;
  logic                 s1;
  logic                 s2;
  logic [2*WIDTH-1:0]   prod_fix;

  // Two's-complement absolute value; -2^(W-1) maps to 2^(W-1) as unsigned.
  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v,
                                                 input logic is_signed);
    if (is_signed && v[WIDTH-1])
      return -v;
    else
      return v;
  endfunction

  function automatic logic [2*WIDTH-1:0] apply_sign(input logic [2*WIDTH-1:0] p,
                                                    input logic n);
    return n ? -p : p;
  endfunction

  always_comb begin
    s1       = (flag == 2'd1) || (flag == 2'd2);
    s2       = (flag == 2'd1);
    prod_fix = apply_sign(acc, neg);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
      hi     <= 1'b0;
      out    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            mcand  <= {{WIDTH{1'b0}}, magnitude($signed(in1), s1)};
            mplier <= magnitude($signed(in2), s2);
            neg    <= (s1 & in1[WIDTH-1]) ^ (s2 & in2[WIDTH-1]);
            hi     <= (flag != 2'd0);
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= CALC;
          end
        end
        CALC: begin
          if (mplier[0])
            acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST)
            state <= FIX;
        end
        FIX: begin
          out   <= hi ? prod_fix[2*WIDTH-1:WIDTH] : prod_fix[WIDTH-1:0];
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multiply.sv
// Directed-vector bench for the sequential multiplier: results, latency,
// asynchronous reset and the start/busy/done handshake.
module tb_multiply;

  logic        clk;
  logic        rst;
  logic        start;
  logic [63:0] in1;
  logic [63:0] in2;
  logic [1:0]  flag;
  logic [63:0] out;
  logic        busy;
  logic        done;

  int vectors;
  int errors;

  multiply #(.WIDTH(64)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .in1   (in1),
    .in2   (in2),
    .flag  (flag),
    .out   (out),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Accept start at the next rising edge; returns at the negedge after it,
  // then scrambles the inputs to show they are not needed after capture.
  task automatic do_start(input logic [63:0] a, input logic [63:0] b, input logic [1:0] f);
    @(negedge clk);
    in1   = a;
    in2   = b;
    flag  = f;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    in1   = ~a;
    in2   = ~b;
    flag  = ~f;
  endtask

  // Counts rising edges until done is seen (bounded at 100).
  task automatic wait_done(output int cycles);
    cycles = 0;
    while (done !== 1'b1 && cycles < 100) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    start = 1'b0;
    in1 = '0;
    in2 = '0;
    flag = '0;
    repeat (2) @(negedge clk);
    vectors++;
    if (out !== 64'd0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: out=%h busy=%b done=%b, required out=0 busy=0 done=0", out, busy, done);
    end
    rst = 1'b0;
  endtask

  task automatic run_table(input string name, input logic [63:0] a [],
                           input logic [63:0] b [], input logic [1:0] f [],
                           input logic [63:0] exp []);
    int cyc;
    for (int i = 0; i < a.size(); i++) begin
      do_start(a[i], b[i], f[i]);
      vectors++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL %s[%0d]_busy: busy=%b after accept, required 1", name, i, busy);
      end
      wait_done(cyc);
      vectors++;
      if (cyc !== 65) begin
        errors++;
        $display("FAIL %s[%0d]_latency: done after %0d edges, required 65", name, i, cyc);
      end
      vectors++;
      if (out !== exp[i]) begin
        errors++;
        $display("FAIL %s[%0d]_out: out=%h, required %h", name, i, out, exp[i]);
      end
      @(negedge clk);
      vectors++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL %s[%0d]_after: done=%b busy=%b, required 0 0", name, i, done, busy);
      end
    end
  endtask

  task automatic test_basic;
    logic [63:0] a [] = '{64'd10, 64'd20};
    logic [63:0] b [] = '{64'd5, -64'sd7};
    logic [1:0]  f [] = '{2'd0, 2'd1};
    logic [63:0] e [] = '{64'h0000000000000032, 64'hFFFFFFFFFFFFFFFF};
    run_table("basic", a, b, f, e);
  endtask

  task automatic test_mixed;
    logic [63:0] a [] = '{-64'sd100, -64'sd51, -64'sd51};
    logic [63:0] b [] = '{64'd10, -64'sd2, -64'sd2};
    logic [1:0]  f [] = '{2'd2, 2'd3, 2'd0};
    logic [63:0] e [] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFCB, 64'h0000000000000066};
    run_table("mixed", a, b, f, e);
  endtask

  task automatic test_edges;
    logic [63:0] a [] = '{64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'd0};
    logic [63:0] b [] = '{64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'h1234};
    logic [1:0]  f [] = '{2'd1, 2'd3, 2'd1, 2'd3};
    logic [63:0] e [] = '{64'h4000000000000000, 64'hFFFFFFFFFFFFFFFE, 64'h0, 64'h0};
    run_table("edges", a, b, f, e);
  endtask

  task automatic test_reset_mid;
    int pulses;
    do_start(64'd7, 64'd9, 2'd0);
    repeat (19) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (out !== 64'd0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: out=%h busy=%b done=%b, required 0 0 0", out, busy, done);
    end
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) pulses++;
    end
    vectors++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL reset_mid_no_done: %0d busy/done cycles seen, required 0", pulses);
    end
  endtask

  task automatic test_ignore_start;
    int cyc;
    do_start(64'd3, 64'd7, 2'd0);
    repeat (9) @(negedge clk);
    in1 = 64'd100;
    in2 = 64'd100;
    flag = 2'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc);
    vectors++;
    if (cyc !== 55) begin
      errors++;
      $display("FAIL ignore_latency: done after %0d more edges, required 55", cyc);
    end
    vectors++;
    if (out !== 64'd21) begin
      errors++;
      $display("FAIL ignore_out: out=%h, required %h", out, 64'd21);
    end
  endtask

  // Entered with done high from test_ignore_start; start lands on the edge
  // that drops done.
  task automatic test_back_to_back;
    int cyc;
    in1 = 64'd6;
    in2 = 64'd9;
    flag = 2'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    in1 = '0;
    in2 = '0;
    vectors++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept: busy=%b done=%b, required 1 0", busy, done);
    end
    repeat (30) @(negedge clk);
    vectors++;
    if (out !== 64'd21) begin
      errors++;
      $display("FAIL b2b_hold: out=%h mid-operation, required %h", out, 64'd21);
    end
    wait_done(cyc);
    vectors++;
    if (cyc !== 35) begin
      errors++;
      $display("FAIL b2b_latency: done after %0d more edges, required 35", cyc);
    end
    vectors++;
    if (out !== 64'd54) begin
      errors++;
      $display("FAIL b2b_out: out=%h, required %h", out, 64'd54);
    end
  endtask

  initial begin
    vectors = 0;
    errors = 0;
    test_reset;
    test_basic;
    test_reset_mid;
    test_mixed;
    test_edges;
    test_ignore_start;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
